axis_throttle_slice: RTL and testbench

- Registered AXI4-stream pass-through stage inserted between any stream source and sink, e.g. between the aggregator `Top` and its feeder or monitor.
- Generalises periodic valid/ready gating into a synthesizable block:
  - runtime-programmable input stall period;
  - runtime-programmable output idle period;
  - optional forced-tlast framing every N beats.
- Fully AXI-compliant: never drops an offered beat, never reorders, never deasserts valid before handshake.

---
 rtl/axis_pkg.sv | 33 +++
 rtl/axis_skid_buffer.sv | 78 +++++++
 rtl/axis_throttle_slice.sv | 172 +++++++++++++++++
 tb/tb_axis_throttle_slice.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared AXI4-stream definitions for the stream slices.
//
// Contents:
//   AXIS_*_DFLT      default beat geometry used by the stream blocks
//   OPERATION        tid code for operation traffic
//   CONFIGURATION    tid code for configuration traffic
//   axis_beat_t      packed beat {tdata, tkeep, tuser, tlast, tid} at the default geometry
//   skid_state_e     occupancy states of the 2-entry skid buffer
package axis_pkg;

    localparam int unsigned AXIS_BYTES_DFLT     = 32;
    localparam int unsigned AXIS_TUSER_BPB_DFLT = 4;
    localparam int unsigned AXIS_TID_BITS_DFLT  = 2;
    localparam int unsigned CNT_BITS_DFLT       = 16;

    localparam logic [1:0] OPERATION     = 2'b01;
    localparam logic [1:0] CONFIGURATION = 2'b11;

    typedef struct packed {
        logic [AXIS_BYTES_DFLT*8-1:0]                   tdata;
        logic [AXIS_BYTES_DFLT-1:0]                     tkeep;
        logic [AXIS_BYTES_DFLT*AXIS_TUSER_BPB_DFLT-1:0] tuser;
        logic                                           tlast;
        logic [AXIS_TID_BITS_DFLT-1:0]                  tid;
    } axis_beat_t;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StFull  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer with EMPTY/ONE/FULL occupancy FSM.
//
// Ports:
//   clk, reset    clock and synchronous active-high reset (discards contents)
//   push_i        beat on data_i is accepted this cycle (caller guarantees not FULL)
//   data_i        incoming beat
//   pop_i         head beat is consumed this cycle (only meaningful when valid_o)
//   valid_o       buffer holds at least one beat
//   data_o        head beat; zero after reset
//   full_next_o   buffer will be FULL next cycle
module axis_skid_buffer
    import axis_pkg::*;
#(
    parameter type beat_t = axis_beat_t
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push_i,
    input  beat_t data_i,
    input  logic  pop_i,
    output logic  valid_o,
    output beat_t data_o,
    output logic  full_next_o
);

    skid_state_e state_q, state_d;
    beat_t       head_q, head_d;
    beat_t       tail_q, tail_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StEmpty;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            StEmpty: begin
                if (push_i) begin
                    state_d = StOne;
                    head_d  = data_i;
                end
            end
            StOne: begin
                if (push_i && pop_i) begin
                    head_d = data_i;
                end else if (push_i) begin
                    state_d = StFull;
                    tail_d  = data_i;
                end else if (pop_i) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // Upstream ready is low while FULL, so only a pop can happen here.
                if (pop_i) begin
                    state_d = StOne;
                    head_d  = tail_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    assign valid_o     = (state_q != StEmpty);
    assign data_o      = head_q;
    assign full_next_o = (state_d == StFull);

endmodule

// File: rtl/axis_throttle_slice.sv
// Registered AXI4-stream pass-through with programmable input stalls, output idle
// slots and optional forced-tlast framing. Never drops, reorders or withdraws a beat.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   io_in_*                    upstream AXI4-stream (valid/ready, tdata, tkeep, tuser, tlast, tid)
//   io_out_*                   downstream AXI4-stream, same fields
//   cfg_in_period              input stall period (0 or 1 = never stall)
//   cfg_out_period             output idle period (0 or 1 = never idle)
//   cfg_frame_beats            force tlast every N beats (0 = pass tlast unchanged)
//   stat_*                     saturating statistics, present only with AXIS_THROTTLE_STATS_EN
//
// Build option: define AXIS_THROTTLE_STATS_EN to add the statistics outputs.
module axis_throttle_slice
    import axis_pkg::*;
#(
    parameter int unsigned AXIS_BYTES     = axis_pkg::AXIS_BYTES_DFLT,
    parameter int unsigned AXIS_TUSER_BPB = axis_pkg::AXIS_TUSER_BPB_DFLT,
    parameter int unsigned AXIS_TID_BITS  = axis_pkg::AXIS_TID_BITS_DFLT,
    parameter int unsigned CNT_BITS       = axis_pkg::CNT_BITS_DFLT
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 io_in_valid,
    output logic                                 io_in_ready,
    input  logic [AXIS_BYTES*8-1:0]              io_in_bits_tdata,
    input  logic [AXIS_BYTES-1:0]                io_in_bits_tkeep,
    input  logic [AXIS_BYTES*AXIS_TUSER_BPB-1:0] io_in_bits_tuser,
    input  logic                                 io_in_bits_tlast,
    input  logic [AXIS_TID_BITS-1:0]             io_in_tid,
    output logic                                 io_out_valid,
    input  logic                                 io_out_ready,
    output logic [AXIS_BYTES*8-1:0]              io_out_bits_tdata,
    output logic [AXIS_BYTES-1:0]                io_out_bits_tkeep,
    output logic [AXIS_BYTES*AXIS_TUSER_BPB-1:0] io_out_bits_tuser,
    output logic                                 io_out_bits_tlast,
    output logic [AXIS_TID_BITS-1:0]             io_out_tid,
    input  logic [CNT_BITS-1:0]                  cfg_in_period,
    input  logic [CNT_BITS-1:0]                  cfg_out_period,
    input  logic [CNT_BITS-1:0]                  cfg_frame_beats
`ifdef AXIS_THROTTLE_STATS_EN
    ,
    output logic [31:0]                          stat_beats_in,
    output logic [31:0]                          stat_beats_out,
    output logic [31:0]                          stat_frames_out,
    output logic [31:0]                          stat_stall_cycles
`endif
);

    typedef struct packed {
        logic [AXIS_BYTES*8-1:0]              tdata;
        logic [AXIS_BYTES-1:0]                tkeep;
        logic [AXIS_BYTES*AXIS_TUSER_BPB-1:0] tuser;
        logic                                 tlast;
        logic [AXIS_TID_BITS-1:0]             tid;
    } beat_t;

    beat_t in_beat, head;
    logic  buf_valid, buf_full_next;
    logic  in_hs, out_hs;
    logic  in_ready_q, in_ready_d;
    logic  pending_q;

    logic [CNT_BITS-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_BITS-1:0] out_cnt_q, out_cnt_d;
    logic [CNT_BITS-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_BITS-1:0] in_last, out_last, frame_last;
    logic                in_active, out_active, frame_active;
    logic                out_slot, frame_hit, tlast_out;

    assign in_beat = '{tdata: io_in_bits_tdata, tkeep: io_in_bits_tkeep,
                       tuser: io_in_bits_tuser, tlast: io_in_bits_tlast, tid: io_in_tid};

    axis_skid_buffer #(
        .beat_t (beat_t)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (in_hs),
        .data_i      (in_beat),
        .pop_i       (out_hs),
        .valid_o     (buf_valid),
        .data_o      (head),
        .full_next_o (buf_full_next)
    );

    // A period of 1 would stall/idle every cycle, so it behaves like 0.
    assign in_active    = (cfg_in_period > CNT_BITS'(1));
    assign out_active   = (cfg_out_period > CNT_BITS'(1));
    assign frame_active = (cfg_frame_beats != '0);
    assign in_last      = cfg_in_period - CNT_BITS'(1);
    assign out_last     = cfg_out_period - CNT_BITS'(1);
    assign frame_last   = cfg_frame_beats - CNT_BITS'(1);

    // '>=' lets a counter left above a shortened period fall back to 0 at once.
    always_comb begin
        in_cnt_d  = (!in_active || in_cnt_q >= in_last) ? '0 : in_cnt_q + CNT_BITS'(1);
        out_cnt_d = (!out_active || out_cnt_q >= out_last) ? '0 : out_cnt_q + CNT_BITS'(1);
    end

    assign out_slot     = out_active && (out_cnt_q == out_last);
    // A pending offer must stay up until taken, even on an idle slot.
    assign io_out_valid = buf_valid && (!out_slot || pending_q);
    assign io_in_ready  = in_ready_q;
    assign in_hs        = io_in_valid && in_ready_q;
    assign out_hs       = io_out_valid && io_out_ready;

    assign frame_hit = frame_active && (beat_cnt_q == frame_last);
    assign tlast_out = head.tlast | (buf_valid & frame_hit);

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (out_hs) begin
            beat_cnt_d = tlast_out ? '0 : beat_cnt_q + CNT_BITS'(1);
        end
        in_ready_d = !buf_full_next && !(in_active && (in_cnt_d == in_last));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            beat_cnt_q <= '0;
            in_ready_q <= 1'b0;
            pending_q  <= 1'b0;
        end else begin
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            in_ready_q <= in_ready_d;
            pending_q  <= io_out_valid && !io_out_ready;
        end
    end

    assign io_out_bits_tdata = head.tdata;
    assign io_out_bits_tkeep = head.tkeep;
    assign io_out_bits_tuser = head.tuser;
    assign io_out_bits_tlast = tlast_out;
    assign io_out_tid        = head.tid;

`ifdef AXIS_THROTTLE_STATS_EN
    logic [31:0] stat_in_q, stat_out_q, stat_frames_q, stat_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_in_q     <= '0;
            stat_out_q    <= '0;
            stat_frames_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (in_hs && stat_in_q != '1) begin
                stat_in_q <= stat_in_q + 32'd1;
            end
            if (out_hs && stat_out_q != '1) begin
                stat_out_q <= stat_out_q + 32'd1;
            end
            if (out_hs && tlast_out && stat_frames_q != '1) begin
                stat_frames_q <= stat_frames_q + 32'd1;
            end
            if (io_out_valid && !io_out_ready && stat_stall_q != '1) begin
                stat_stall_q <= stat_stall_q + 32'd1;
            end
        end
    end

    assign stat_beats_in     = stat_in_q;
    assign stat_beats_out    = stat_out_q;
    assign stat_frames_out   = stat_frames_q;
    assign stat_stall_cycles = stat_stall_q;
`endif

endmodule

// File: tb/tb_axis_throttle_slice.sv
// Self-checking bench for axis_throttle_slice: a queue-based stream model checks every
// cycle, plus literal expectations for each directed scenario.
module tb_axis_throttle_slice;

    localparam int unsigned B   = 32;
    localparam int unsigned BPB = 4;
    localparam int unsigned TID = 2;
    localparam int unsigned CB  = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 io_in_valid, io_in_ready;
    logic [B*8-1:0]       io_in_bits_tdata;
    logic [B-1:0]         io_in_bits_tkeep;
    logic [B*BPB-1:0]     io_in_bits_tuser;
    logic                 io_in_bits_tlast;
    logic [TID-1:0]       io_in_tid;
    logic                 io_out_valid, io_out_ready;
    logic [B*8-1:0]       io_out_bits_tdata;
    logic [B-1:0]         io_out_bits_tkeep;
    logic [B*BPB-1:0]     io_out_bits_tuser;
    logic                 io_out_bits_tlast;
    logic [TID-1:0]       io_out_tid;
    logic [CB-1:0]        cfg_in_period, cfg_out_period, cfg_frame_beats;
`ifdef AXIS_THROTTLE_STATS_EN
    logic [31:0]          stat_beats_in, stat_beats_out, stat_frames_out, stat_stall_cycles;
`endif

    axis_throttle_slice dut (
        .clk               (clk),
        .reset             (reset),
        .io_in_valid       (io_in_valid),
        .io_in_ready       (io_in_ready),
        .io_in_bits_tdata  (io_in_bits_tdata),
        .io_in_bits_tkeep  (io_in_bits_tkeep),
        .io_in_bits_tuser  (io_in_bits_tuser),
        .io_in_bits_tlast  (io_in_bits_tlast),
        .io_in_tid         (io_in_tid),
        .io_out_valid      (io_out_valid),
        .io_out_ready      (io_out_ready),
        .io_out_bits_tdata (io_out_bits_tdata),
        .io_out_bits_tkeep (io_out_bits_tkeep),
        .io_out_bits_tuser (io_out_bits_tuser),
        .io_out_bits_tlast (io_out_bits_tlast),
        .io_out_tid        (io_out_tid),
        .cfg_in_period     (cfg_in_period),
        .cfg_out_period    (cfg_out_period),
        .cfg_frame_beats   (cfg_frame_beats)
`ifdef AXIS_THROTTLE_STATS_EN
        ,
        .stat_beats_in     (stat_beats_in),
        .stat_beats_out    (stat_beats_out),
        .stat_frames_out   (stat_frames_out),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- stimulus driver ----------------
    int beat_idx, beats_total, tlast_at;

    task automatic drive_inputs();
        logic [31:0] v;
        v = 32'(beat_idx);
        io_in_valid      = (beat_idx < beats_total);
        io_in_bits_tdata = {8{v}};
        io_in_bits_tkeep = ~v;
        io_in_bits_tuser = {4{v ^ 32'hA5A5_0000}};
        io_in_bits_tlast = (beat_idx == tlast_at);
        io_in_tid        = v[1:0];
    endtask

    task automatic step();
        logic hs;
        @(negedge clk);
        hs = io_in_valid && io_in_ready;
        @(posedge clk);
        #1;
        if (hs) beat_idx++;
        drive_inputs();
    endtask

    // ---------------- stream model / compare ----------------
    typedef struct packed {
        logic [B*8-1:0]   d;
        logic [B-1:0]     k;
        logic [B*BPB-1:0] u;
        logic             l;
        logic [TID-1:0]   id;
    } beat_s;

    beat_s exp_q[$];
    int    out_log[$];
    int    tlast_log[$];
    int    rlow[$];
    logic  vhist[0:511];
    logic  rhist[0:511];
    int    k, frame_pos, out_count, first_k, last_k;
    logic  prev_v, prev_r;

    always @(negedge clk) begin
        int    occ, pin, pout, nfr;
        logic  e_ready, e_valid, e_last;
        beat_s b;
        if (reset) begin
            exp_q.delete();
            out_log.delete();
            tlast_log.delete();
            rlow.delete();
            k = 0;
            frame_pos = 0;
            out_count = 0;
            first_k = -1;
            last_k = -1;
            prev_v = 1'b0;
            prev_r = 1'b0;
        end else begin
            occ  = exp_q.size();
            pin  = int'(cfg_in_period);
            pout = int'(cfg_out_period);
            nfr  = int'(cfg_frame_beats);
            // Ready: not in the post-reset cycle, room for a beat, not on the stall slot.
            e_ready = (k > 0) && (occ < 2) && !(pin > 1 && (k % pin) == pin - 1);
            // Valid: data held, and either not an idle slot or an offer still pending.
            e_valid = (occ > 0) && (!(pout > 1 && (k % pout) == pout - 1) || (prev_v && !prev_r));
            chk("in_ready", io_in_ready, e_ready);
            chk("out_valid", io_out_valid, e_valid);
            if (io_out_valid) begin
                if (occ == 0) begin
                    chk("spurious_beat", io_out_valid, 1'b0);
                end else begin
                    b = exp_q[0];
                    e_last = b.l || (nfr > 0 && frame_pos == nfr - 1);
                    chk("out_tdata", io_out_bits_tdata, b.d);
                    chk("out_tkeep", io_out_bits_tkeep, b.k);
                    chk("out_tuser", io_out_bits_tuser, b.u);
                    chk("out_tid", io_out_tid, b.id);
                    chk("out_tlast", io_out_bits_tlast, e_last);
                    if (io_out_ready) begin
                        out_log.push_back(int'(io_out_bits_tdata[31:0]));
                        if (io_out_bits_tlast) tlast_log.push_back(out_count);
                        frame_pos = e_last ? 0 : frame_pos + 1;
                        void'(exp_q.pop_front());
                        out_count++;
                        if (first_k < 0) first_k = k;
                        last_k = k;
                    end
                end
            end
            if (io_in_valid && io_in_ready) begin
                exp_q.push_back('{d: io_in_bits_tdata, k: io_in_bits_tkeep, u: io_in_bits_tuser,
                                  l: io_in_bits_tlast, id: io_in_tid});
            end
            if (k > 0 && !io_in_ready) rlow.push_back(k);
            if (k < 512) begin
                vhist[k] = io_out_valid;
                rhist[k] = io_in_ready;
            end
            prev_v = io_out_valid;
            prev_r = io_out_ready;
            k++;
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        beats_total = 0;
        beat_idx = 0;
        tlast_at = -1;
        drive_inputs();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("rst_out_valid", io_out_valid, 1'b0);
        chk("rst_in_ready", io_in_ready, 1'b0);
        chk("rst_tdata", io_out_bits_tdata, '0);
        chk("rst_tlast", io_out_bits_tlast, 1'b0);
        chk("rst_tid", io_out_tid, '0);
`ifdef AXIS_THROTTLE_STATS_EN
        chk("rst_stat_in", stat_beats_in, '0);
        chk("rst_stat_out", stat_beats_out, '0);
        chk("rst_stat_frames", stat_frames_out, '0);
        chk("rst_stat_stall", stat_stall_cycles, '0);
`endif
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        io_out_ready = 1'b0;
        cfg_in_period = '0;
        cfg_out_period = '0;
        cfg_frame_beats = '0;
        beat_idx = 0;
        beats_total = 0;
        tlast_at = -1;
        drive_inputs();

        // 1: ungated pass-through of 100 beats
        io_out_ready = 1'b1;
        do_reset();
        beats_total = 100;
        drive_inputs();
        for (int c = 0; c < 110; c++) step();
        chk("t1_count", out_count, 100);
        chk("t1_first_k", first_k, 2);
        chk("t1_span", last_k - first_k, 99);
        chk("t1_ready_low", rlow.size(), 0);
        if (out_log.size() == 100) chk("t1_last_data", out_log[99], 99);

`ifdef AXIS_THROTTLE_STATS_EN
        chk("t1_stat_in", stat_beats_in, 100);
        chk("t1_stat_out", stat_beats_out, 100);
`endif

        // 2: input stall period 64
        cfg_in_period = 16'd64;
        do_reset();
        beats_total = 100000;
        drive_inputs();
        for (int c = 0; c < 257; c++) step();
        chk("t2_stalls", rlow.size(), 4);
        if (rlow.size() >= 4) begin
            chk("t2_first_stall", rlow[0], 63);
            chk("t2_spacing", rlow[1] - rlow[0], 64);
            chk("t2_last_stall", rlow[3], 255);
        end
        chk("t2_count", out_count, 251);
        cfg_in_period = '0;

        // 3: output idle period 128 with a pending offer on the slot
        cfg_out_period = 16'd128;
        do_reset();
        beats_total = 100000;
        drive_inputs();
        for (int c = 0; c < 260; c++) begin
            io_out_ready = !(c == 126 || c == 127);
            step();
        end
        chk("t3_pending_held", vhist[127], 1'b1);
        chk("t3_before_slot", vhist[126], 1'b1);
        chk("t3_slot_suppressed", vhist[255], 1'b0);
        cfg_out_period = '0;
        io_out_ready = 1'b1;

        // 4a: forced framing every 4 beats
        cfg_frame_beats = 16'd4;
        do_reset();
        beats_total = 12;
        drive_inputs();
        for (int c = 0; c < 20; c++) step();
        chk("t4a_frames", tlast_log.size(), 3);
        if (tlast_log.size() == 3) begin
            chk("t4a_tlast0", tlast_log[0], 3);
            chk("t4a_tlast1", tlast_log[1], 7);
            chk("t4a_tlast2", tlast_log[2], 11);
        end

        // 4b: input tlast on beat 1 restarts the frame
        do_reset();
        beats_total = 12;
        tlast_at = 1;
        drive_inputs();
        for (int c = 0; c < 20; c++) step();
        chk("t4b_frames", tlast_log.size(), 3);
        if (tlast_log.size() == 3) begin
            chk("t4b_tlast0", tlast_log[0], 1);
            chk("t4b_tlast1", tlast_log[1], 5);
            chk("t4b_tlast2", tlast_log[2], 9);
        end
        cfg_frame_beats = '0;

        // 5: backpressure fills the buffer, then drains in order
        do_reset();
        beats_total = 3;
        drive_inputs();
        for (int c = 0; c < 25; c++) begin
            io_out_ready = (c >= 10);
            step();
        end
        chk("t5_ready_before_full", rhist[2], 1'b1);
        chk("t5_ready_full", rhist[5], 1'b0);
        chk("t5_first_k", first_k, 10);
        chk("t5_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("t5_order0", out_log[0], 0);
            chk("t5_order1", out_log[1], 1);
            chk("t5_order2", out_log[2], 2);
        end

        // 6: reset while FULL discards buffered beats
        io_out_ready = 1'b0;
        do_reset();
        beats_total = 5;
        drive_inputs();
        for (int c = 0; c < 6; c++) step();
        chk("t6_full", rhist[4], 1'b0);
        chk("t6_valid_before", io_out_valid, 1'b1);
        do_reset();
        io_out_ready = 1'b1;
        for (int c = 0; c < 10; c++) step();
        chk("t6_valid_after", vhist[0], 1'b0);
        chk("t6_no_stale", out_count, 0);

        // 7: period 1 behaves like 0
        cfg_in_period = 16'd1;
        cfg_out_period = 16'd1;
        do_reset();
        beats_total = 20;
        drive_inputs();
        for (int c = 0; c < 25; c++) step();
        chk("t7_ready_low", rlow.size(), 0);
        chk("t7_count", out_count, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
